mult_arbiter: RTL and testbench

//  Round-robin front end for the shared_mult multiplier: lets NUM_REQ client instances (voices, filters)

---
 rtl/dsp_pkg.sv | 22 ++
 rtl/mult_arbiter_if.sv | 25 ++
 rtl/rr_arbiter.sv | 40 ++++
 rtl/shared_mult.sv | 31 +++
 rtl/mult_arbiter.sv | 111 +++++++++++
 tb/tb_mult_arbiter.sv | 263 ++++++++++++++++++++++++++
 6 files changed

// File: rtl/dsp_pkg.sv
// Shared types and helpers for the DSP resource front ends (operand/product types, tags).
package dsp_pkg;

    localparam int MULT_W   = 32;
    localparam int PROD_W   = 64;
    localparam int MAX_REQ  = 32;
    localparam int MAX_ID_W = 5;

    typedef logic signed [MULT_W-1:0] op_t;
    typedef logic signed [PROD_W-1:0] prod_t;

    // One in-flight multiply: who issued it and whether the slot is occupied.
    typedef struct packed {
        logic                valid;
        logic [MAX_ID_W-1:0] id;
    } tag_t;

    function automatic logic [MAX_REQ-1:0] onehot(input logic [MAX_ID_W-1:0] id);
        return MAX_REQ'(1) << id;
    endfunction

endpackage

// File: rtl/mult_arbiter_if.sv
// Client-side request/response bundle of the shared multiplier front end.
interface mult_arbiter_if
    import dsp_pkg::*;
#(
    parameter int NUM_REQ = 8
) ();

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*MULT_W-1:0] req_a;
    logic [NUM_REQ*MULT_W-1:0] req_b;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        resp_valid;
    prod_t                     resp_p;

    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, resp_valid, resp_p
    );

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, resp_valid, resp_p
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr, wrapping, wins.
module rr_arbiter #(
    parameter  int N    = 8,
    localparam int ID_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] gnt_id,
    output logic            any
);

    localparam logic [ID_W:0] N_W = (ID_W+1)'(N);

    logic [ID_W-1:0] rot_idx [N];
    logic [N-1:0]    rot_req;

    // Slot gi of the rotated view is client (ptr + gi) mod N.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_rot
            wire [ID_W:0] sum = {1'b0, ptr} + (ID_W+1)'(gi);
            assign rot_idx[gi] = (sum >= N_W) ? ID_W'(sum - N_W) : ID_W'(sum);
            assign rot_req[gi] = req[rot_idx[gi]];
        end
    endgenerate

    always_comb begin
        gnt_id = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot_req[k]) begin
                gnt_id = rot_idx[k];
            end
        end
    end

    assign any   = |req;
    assign grant = any ? (N'(1) << gnt_id) : '0;

endmodule

// File: rtl/shared_mult.sv
// Pipelined signed 32x32 multiplier; product appears MULT_LAT cycles after the operands.
module shared_mult
    import dsp_pkg::*;
#(
    parameter int MULT_LAT = 2
) (
    input  logic  clk,
    input  logic  rst_n,
    input  op_t   a,
    input  op_t   b,
    output prod_t p
);

    prod_t pipe_reg [MULT_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < MULT_LAT; s++) begin
                pipe_reg[s] <= '0;
            end
        end else begin
            pipe_reg[0] <= prod_t'(a) * prod_t'(b);
            for (int s = 1; s < MULT_LAT; s++) begin
                pipe_reg[s] <= pipe_reg[s-1];
            end
        end
    end

    assign p = pipe_reg[MULT_LAT-1];

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin front end for shared_mult: one operand pair issued per cycle, products
// routed back to their issuer through a tag pipeline matched to the multiplier latency.
module mult_arbiter
    import dsp_pkg::*;
#(
    parameter  int NUM_REQ  = 8,
    parameter  int MULT_LAT = 2,
    localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    mult_arbiter_if.slave  bus,
    output op_t            m_a,
    output op_t            m_b,
    input  prod_t          m_p
);

    op_t a_arr [NUM_REQ];
    op_t b_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign a_arr[gi] = bus.req_a[MULT_W*gi +: MULT_W];
            assign b_arr[gi] = bus.req_b[MULT_W*gi +: MULT_W];
        end
    endgenerate

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    gnt_id;
    logic [ID_W-1:0]    ptr_reg;
    logic [ID_W-1:0]    ptr_next;
    logic               any_req;
    logic               transfer;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req    (bus.req_valid),
        .ptr    (ptr_reg),
        .grant  (grant),
        .gnt_id (gnt_id),
        .any    (any_req)
    );

    // Grants are withheld while reset is asserted so nothing is lost into a held pipeline.
    assign bus.req_ready = rst_n ? grant : '0;
    assign transfer      = any_req & rst_n;
    assign ptr_next      = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= '0;
        end else if (transfer) begin
            ptr_reg <= ptr_next;
        end
    end

    // Operands hold when idle; the multiplier's output is then ignored via the tag.
    op_t m_a_reg;
    op_t m_b_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_a_reg <= '0;
            m_b_reg <= '0;
        end else if (transfer) begin
            m_a_reg <= a_arr[gnt_id];
            m_b_reg <= b_arr[gnt_id];
        end
    end

    assign m_a = m_a_reg;
    assign m_b = m_b_reg;

    tag_t tag_in;
    tag_t tag_reg [MULT_LAT+1];

    assign tag_in = '{valid: transfer, id: MAX_ID_W'(gnt_id)};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s <= MULT_LAT; s++) begin
                tag_reg[s] <= '0;
            end
        end else begin
            tag_reg[0] <= tag_in;
            for (int s = 1; s <= MULT_LAT; s++) begin
                tag_reg[s] <= tag_reg[s-1];
            end
        end
    end

    // The last tag stage lines up with the product currently on m_p.
    logic [NUM_REQ-1:0] resp_valid_reg;
    prod_t              resp_p_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_reg <= '0;
            resp_p_reg     <= '0;
        end else if (tag_reg[MULT_LAT].valid) begin
            resp_valid_reg <= NUM_REQ'(onehot(tag_reg[MULT_LAT].id));
            resp_p_reg     <= m_p;
        end else begin
            resp_valid_reg <= '0;
        end
    end

    assign bus.resp_valid = resp_valid_reg;
    assign bus.resp_p     = resp_p_reg;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed and random checks of mult_arbiter driving a shared_mult with NUM_REQ=4, MULT_LAT=2.
module tb_mult_arbiter;
    import dsp_pkg::*;

    localparam int N   = 4;
    localparam int LAT = 2;
    localparam int RESP_DLY = LAT + 2;   // cycles from the transfer cycle to the response cycle

    logic  clk = 1'b0;
    logic  rst_n;
    op_t   m_a;
    op_t   m_b;
    prod_t m_p;

    always #5 clk = ~clk;

    mult_arbiter_if #(.NUM_REQ(N)) bus ();

    mult_arbiter #(.NUM_REQ(N), .MULT_LAT(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave),
        .m_a   (m_a),
        .m_b   (m_b),
        .m_p   (m_p)
    );

    shared_mult #(.MULT_LAT(LAT)) u_mult (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (m_a),
        .b     (m_b),
        .p     (m_p)
    );

    int total = 0;
    int bad   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.req_valid = '0;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
        bus.req_a[32*i +: 32] = a;
        bus.req_b[32*i +: 32] = b;
        bus.req_valid[i]      = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 32'(i + 7), 32'(i + 9));
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b exp=0000", bus.req_ready); end
        total++; if (bus.resp_valid !== 4'b0000) begin bad++; $display("FAIL reset_resp_valid got=%b exp=0000", bus.resp_valid); end
        total++; if (bus.resp_p !== prod_t'(0)) begin bad++; $display("FAIL reset_resp_p got=%0d exp=0", bus.resp_p); end
        total++; if (m_a !== op_t'(0) || m_b !== op_t'(0)) begin bad++; $display("FAIL reset_mab got=%h/%h exp=0/0", m_a, m_b); end
        idle();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_contention();
        logic [3:0] exp_rdy;
        logic [3:0] exp_rv;
        prod_t      exp_p;
        for (int c = 0; c < 12; c++) begin
            if (c < 8) begin
                for (int i = 0; i < N; i++) set_req(i, 32'(i + 1), 32'd1000);
            end else begin
                idle();
            end
            #1;
            exp_rdy = (c < 8) ? 4'(1 << (c % 4)) : 4'b0000;
            total++; if (bus.req_ready !== exp_rdy) begin bad++; $display("FAIL contention_ready c=%0d got=%b exp=%b", c, bus.req_ready, exp_rdy); end
            if (c >= RESP_DLY && c - RESP_DLY < 8) begin
                exp_rv = 4'(1 << ((c - RESP_DLY) % 4));
                exp_p  = prod_t'(((c - RESP_DLY) % 4 + 1) * 1000);
                total++; if (bus.resp_valid !== exp_rv || bus.resp_p !== exp_p) begin bad++; $display("FAIL contention_resp c=%0d got=%b/%0d exp=%b/%0d", c, bus.resp_valid, bus.resp_p, exp_rv, exp_p); end
            end else begin
                total++; if (bus.resp_valid !== 4'b0000) begin bad++; $display("FAIL contention_idle c=%0d got=%b exp=0000", c, bus.resp_valid); end
            end
            tick();
        end
        idle();
    endtask

    task automatic test_single();
        idle();
        set_req(2, 32'd3, 32'hFFFF_FFFB);
        #1;
        total++; if (bus.req_ready !== 4'b0100) begin bad++; $display("FAIL single_ready got=%b exp=0100", bus.req_ready); end
        tick();
        idle();
        total++; if (m_a !== op_t'(3) || m_b !== op_t'(-5)) begin bad++; $display("FAIL single_issue got=%0d/%0d exp=3/-5", m_a, m_b); end
        for (int k = 1; k <= 6; k++) begin
            if (k == RESP_DLY) begin
                total++; if (bus.resp_valid !== 4'b0100 || bus.resp_p !== prod_t'(-15)) begin bad++; $display("FAIL single_resp got=%b/%0d exp=0100/-15", bus.resp_valid, bus.resp_p); end
            end else begin
                total++; if (bus.resp_valid !== 4'b0000) begin bad++; $display("FAIL single_idle k=%0d got=%b exp=0000", k, bus.resp_valid); end
            end
            tick();
        end
    endtask

    task automatic test_wrap();
        // The single test left the pointer at 3.
        idle();
        set_req(1, 32'd10, 32'd1);
        set_req(3, 32'd30, 32'd1);
        #1;
        total++; if (bus.req_ready !== 4'b1000) begin bad++; $display("FAIL wrap_first got=%b exp=1000", bus.req_ready); end
        tick();
        bus.req_valid[3] = 1'b0;
        #1;
        total++; if (bus.req_ready !== 4'b0010) begin bad++; $display("FAIL wrap_second got=%b exp=0010", bus.req_ready); end
        tick();
        bus.req_valid = '1;
        #1;
        total++; if (bus.req_ready !== 4'b0100) begin bad++; $display("FAIL wrap_ptr got=%b exp=0100", bus.req_ready); end
        idle();
        for (int k = 2; k <= 6; k++) begin
            if (k == 4) begin
                total++; if (bus.resp_valid !== 4'b1000 || bus.resp_p !== prod_t'(30)) begin bad++; $display("FAIL wrap_resp3 got=%b/%0d exp=1000/30", bus.resp_valid, bus.resp_p); end
            end else if (k == 5) begin
                total++; if (bus.resp_valid !== 4'b0010 || bus.resp_p !== prod_t'(10)) begin bad++; $display("FAIL wrap_resp1 got=%b/%0d exp=0010/10", bus.resp_valid, bus.resp_p); end
            end else begin
                total++; if (bus.resp_valid !== 4'b0000) begin bad++; $display("FAIL wrap_idle k=%0d got=%b exp=0000", k, bus.resp_valid); end
            end
            tick();
        end
    endtask

    task automatic test_extremes();
        prod_t all_ones;
        all_ones = '1;
        idle();
        set_req(0, 32'h8000_0000, 32'h8000_0000);
        tick();
        idle();
        set_req(1, 32'hFFFF_FFFF, 32'd1);
        #1;
        total++; if (m_a !== op_t'(32'h8000_0000)) begin bad++; $display("FAIL extreme_issue got=%h exp=80000000", m_a); end
        tick();
        idle();
        for (int k = 2; k <= 6; k++) begin
            if (k == 4) begin
                total++; if (bus.resp_valid !== 4'b0001 || bus.resp_p !== prod_t'(64'h4000_0000_0000_0000)) begin bad++; $display("FAIL extreme_min got=%b/%h exp=0001/4000000000000000", bus.resp_valid, bus.resp_p); end
            end else if (k == 5) begin
                total++; if (bus.resp_valid !== 4'b0010 || bus.resp_p !== all_ones) begin bad++; $display("FAIL extreme_neg got=%b/%h exp=0010/ffffffffffffffff", bus.resp_valid, bus.resp_p); end
            end else begin
                total++; if (bus.resp_valid !== 4'b0000) begin bad++; $display("FAIL extreme_idle k=%0d got=%b exp=0000", k, bus.resp_valid); end
            end
            tick();
        end
    endtask

    task automatic test_reset_midflight();
        for (int i = 0; i < N; i++) set_req(i, 32'(100 + i), 32'd3);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL midreset_ready got=%b exp=0000", bus.req_ready); end
        total++; if (bus.resp_valid !== 4'b0000 || bus.resp_p !== prod_t'(0)) begin bad++; $display("FAIL midreset_resp got=%b/%0d exp=0000/0", bus.resp_valid, bus.resp_p); end
        total++; if (m_a !== op_t'(0) || m_b !== op_t'(0)) begin bad++; $display("FAIL midreset_mab got=%h/%h exp=0/0", m_a, m_b); end
        idle();
        repeat (2) tick();
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            total++; if (bus.resp_valid !== 4'b0000) begin bad++; $display("FAIL midreset_drop k=%0d got=%b exp=0000", k, bus.resp_valid); end
            tick();
        end
        bus.req_valid = '1;
        #1;
        total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL midreset_ptr got=%b exp=0001", bus.req_ready); end
        idle();
        tick();
    endtask

    typedef struct {
        int     id;
        longint p;
        int     due;
    } exp_t;

    task automatic test_random();
        localparam int CYC = 10000;
        exp_t       q[$];
        exp_t       e;
        int         ra [N];
        int         rb [N];
        int         wait_cnt [N];
        logic [N-1:0] pend;
        int         model_ptr;
        int         g;
        logic [3:0] exp_rdy;
        model_ptr = 0;
        pend = '0;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        for (int c = 0; c < CYC + 16; c++) begin
            if (q.size() > 0 && q[0].due == c) begin
                e = q.pop_front();
                total++; if (bus.resp_valid !== 4'(1 << e.id) || bus.resp_p !== prod_t'(e.p)) begin bad++; $display("FAIL random_resp c=%0d got=%b/%h exp=%b/%h", c, bus.resp_valid, bus.resp_p, 4'(1 << e.id), e.p); end
            end else begin
                total++; if (bus.resp_valid !== 4'b0000) begin bad++; $display("FAIL random_idle c=%0d got=%b exp=0000", c, bus.resp_valid); end
            end
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && c < CYC && $urandom_range(0, 2) != 0) begin
                    pend[i] = 1'b1;
                    ra[i] = int'($urandom);
                    rb[i] = int'($urandom);
                    if ($urandom_range(0, 15) == 0) ra[i] = int'(32'h8000_0000);
                    wait_cnt[i] = 0;
                    bus.req_a[32*i +: 32] = ra[i];
                    bus.req_b[32*i +: 32] = rb[i];
                end
            end
            bus.req_valid = pend;
            #1;
            g = -1;
            for (int k = 0; k < N; k++) begin
                if (g < 0 && pend[(model_ptr + k) % N]) g = (model_ptr + k) % N;
            end
            exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
            total++; if (bus.req_ready !== exp_rdy) begin bad++; $display("FAIL random_ready c=%0d got=%b exp=%b", c, bus.req_ready, exp_rdy); end
            if (g >= 0) begin
                total++; if (wait_cnt[g] >= N) begin bad++; $display("FAIL random_starve c=%0d client=%0d waited=%0d limit=%0d", c, g, wait_cnt[g], N - 1); end
                e.id  = g;
                e.p   = longint'(ra[g]) * longint'(rb[g]);
                e.due = c + RESP_DLY;
                q.push_back(e);
                pend[g] = 1'b0;
                model_ptr = (g + 1) % N;
            end
            for (int i = 0; i < N; i++) if (pend[i]) wait_cnt[i]++;
            tick();
        end
        idle();
        total++; if (q.size() != 0) begin bad++; $display("FAIL random_drain got=%0d exp=0 outstanding", q.size()); end
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        test_reset();
        test_contention();
        test_single();
        test_wrap();
        test_extremes();
        test_reset_midflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
